// File: rtl/ctu_efc_dr_shft_pkg.sv
// Shared CTU JTAG definitions: DR shift FSM state encoding and default DR width.
package ctu_efc_dr_shft_pkg;

    // Default efuse data-register length in bits
    localparam int DR_WIDTH = 32;

    // Two-bit state encoding shared with other CTU JTAG controllers
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CAPT  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        CAPT  = ST_CAPT,
        SHIFT = ST_SHIFT,
        DONE  = ST_DONE
    } dr_state_t;

endpackage

// File: rtl/ctu_efc_dr_shft.sv
// CTU-side DR shift controller for the efuse cluster: one start request runs an
// optional capture followed by a WIDTH-bit shift that writes dr_wr_data into the
// efuse register while collecting its previous content into dr_rd_data.
module ctu_efc_dr_shft
    import ctu_efc_dr_shft_pkg::*;
#(
    parameter int WIDTH = DR_WIDTH
) (
    input  logic             tck,
    input  logic             tck_rst,
    input  logic             dr_start,
    input  logic             dr_capture_en,
    input  logic [WIDTH-1:0] dr_wr_data,
    output logic             dr_busy,
    output logic             dr_done,
    output logic [WIDTH-1:0] dr_rd_data,
    output logic             ctu_efc_capturedr,
    output logic             ctu_efc_shiftdr,
    output logic             ctu_efc_data_in,
    input  logic             efc_ctu_data_out
);

    // One extra count bit so the final increment to WIDTH never wraps
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    dr_state_t        state;
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] tx_sr;
    logic [WIDTH-1:0] rx_sr;

    // Sequencing FSM and shift counter; start is only honoured in IDLE
    always_ff @(posedge tck or posedge tck_rst) begin
        if (tck_rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (dr_start) begin
                        bit_cnt <= '0;
                        state   <= dr_capture_en ? CAPT : SHIFT;
                    end
                end
                CAPT: begin
                    state <= SHIFT;
                end
                SHIFT: begin
                    bit_cnt <= bit_cnt + CNT_ONE;
                    if (bit_cnt == CNT_LAST) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Write and read shifters: load on acceptance, shift MSB-first while in SHIFT
    always_ff @(posedge tck or posedge tck_rst) begin
        if (tck_rst) begin
            tx_sr <= '0;
            rx_sr <= '0;
        end else if (state == IDLE && dr_start) begin
            tx_sr <= dr_wr_data;
        end else if (state == SHIFT) begin
            tx_sr <= {tx_sr[WIDTH-2:0], 1'b0};
            rx_sr <= {rx_sr[WIDTH-2:0], efc_ctu_data_out};
        end
    end

    // Outputs decode straight from state and shifter flops, no input feedthrough
    assign ctu_efc_capturedr = (state == CAPT);
    assign ctu_efc_shiftdr   = (state == SHIFT);
    assign ctu_efc_data_in   = tx_sr[WIDTH-1];
    assign dr_busy           = (state != IDLE);
    assign dr_done           = (state == DONE);
    assign dr_rd_data        = rx_sr;

endmodule

// File: tb/tb_ctu_efc_dr_shft.sv
// Testbench for ctu_efc_dr_shft with a behavioural efuse shift register on the
// far side of the serial link and randomized transactions.
module tb_ctu_efc_dr_shft;

    localparam int W = 32;

    logic         tck;
    logic         tck_rst;
    logic         dr_start;
    logic         dr_capture_en;
    logic [W-1:0] dr_wr_data;
    logic         dr_busy;
    logic         dr_done;
    logic [W-1:0] dr_rd_data;
    logic         capt;
    logic         shft;
    logic         din;
    logic         dout;

    int n_vec  = 0;
    int n_miss = 0;

    // Far-end efuse register: capture loads fuse_val, shift moves MSB out first
    logic [W-1:0] efuse_sr;
    logic [W-1:0] fuse_val;
    logic [W-1:0] pre_val;
    logic         pre_en;

    // Expected efuse content and expected held read word
    logic [W-1:0] efuse_exp;
    logic [W-1:0] last_rd;

    ctu_efc_dr_shft #(.WIDTH(W)) dut (
        .tck               (tck),
        .tck_rst           (tck_rst),
        .dr_start          (dr_start),
        .dr_capture_en     (dr_capture_en),
        .dr_wr_data        (dr_wr_data),
        .dr_busy           (dr_busy),
        .dr_done           (dr_done),
        .dr_rd_data        (dr_rd_data),
        .ctu_efc_capturedr (capt),
        .ctu_efc_shiftdr   (shft),
        .ctu_efc_data_in   (din),
        .efc_ctu_data_out  (dout)
    );

    initial tck = 1'b0;
    always #5 tck = ~tck;

    // Efuse side model, independent of the controller's reset
    always @(posedge tck) begin
        if (pre_en)
            efuse_sr <= pre_val;
        else if (capt)
            efuse_sr <= fuse_val;
        else if (shft)
            efuse_sr <= {efuse_sr[W-2:0], din};
    end

    assign dout = efuse_sr[W-1];

    task automatic checkOutput(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [W-1:0] v);
        @(negedge tck);
        pre_val = v;
        pre_en  = 1'b1;
        @(negedge tck);
        pre_en    = 1'b0;
        efuse_exp = v;
    endtask

    // One transaction started at the next negedge; optional extra start pulses
    // in cycle busy_pulse and in the DONE cycle must be ignored.
    task automatic applyStimulus(input bit cap, input logic [W-1:0] wr, input logic [W-1:0] fuse,
                                 input int busy_pulse, input bit done_pulse);
        logic [W-1:0] exp_rd;
        int done_cyc;
        int capt_n;
        int shft_n;
        int busy_low;
        exp_rd   = cap ? fuse : efuse_exp;
        done_cyc = 0;
        capt_n   = 0;
        shft_n   = 0;
        busy_low = 0;
        @(negedge tck);
        checkOutput("idle_busy", W'(dr_busy), '0);
        checkOutput("idle_done", W'(dr_done), '0);
        checkOutput("rd_hold", dr_rd_data, last_rd);
        fuse_val      = fuse;
        dr_start      = 1'b1;
        dr_capture_en = cap;
        dr_wr_data    = wr;
        @(negedge tck);
        dr_start      = 1'b0;
        dr_capture_en = 1'($urandom);
        dr_wr_data    = $urandom;
        for (int c = 1; c <= W + 8; c++) begin
            if (c > 1) @(negedge tck);
            dr_start = 1'b0;
            if (c == busy_pulse) dr_start = 1'b1;
            capt_n += int'(capt);
            shft_n += int'(shft);
            if (dr_done) begin
                done_cyc = c;
                break;
            end
            if (!dr_busy) busy_low++;
        end
        checkOutput("done_cycle", W'(done_cyc), W'(cap ? W + 2 : W + 1));
        checkOutput("busy_in_done", W'(dr_busy), W'(1));
        checkOutput("busy_gaps", W'(busy_low), '0);
        checkOutput("capt_cycles", W'(capt_n), W'(cap ? 1 : 0));
        checkOutput("shift_cycles", W'(shft_n), W'(W));
        checkOutput("rd_data", dr_rd_data, exp_rd);
        checkOutput("efuse_after", efuse_sr, wr);
        last_rd   = exp_rd;
        efuse_exp = wr;
        if (done_pulse) begin
            dr_start = 1'b1;
            @(negedge tck);
            dr_start = 1'b0;
            checkOutput("done_start_ignored", W'(dr_busy), '0);
        end
    endtask

    // Idle window: nothing may start and no stray done may appear
    task automatic idleWatch(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge tck);
            checkOutput("idle_watch", W'({dr_busy, dr_done}), '0);
        end
    endtask

    // Reset after ten shift edges of a capture transaction
    task automatic resetMidShift();
        @(negedge tck);
        fuse_val      = $urandom;
        dr_start      = 1'b1;
        dr_capture_en = 1'b1;
        dr_wr_data    = $urandom;
        @(negedge tck);
        dr_start = 1'b0;
        repeat (11) @(negedge tck);
        checkOutput("pre_rst_shift", W'(shft), W'(1));
        tck_rst = 1'b1;
        #1;
        checkOutput("rst_outs", W'({dr_busy, dr_done, capt, shft, din}), '0);
        checkOutput("rst_rd", dr_rd_data, '0);
        @(negedge tck);
        tck_rst = 1'b0;
        last_rd = '0;
        @(negedge tck);
        checkOutput("post_rst_idle", W'({dr_busy, shft}), '0);
    endtask

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        bit           cap;
        tck_rst       = 1'b1;
        dr_start      = 1'b0;
        dr_capture_en = 1'b0;
        dr_wr_data    = '0;
        pre_en        = 1'b0;
        pre_val       = '0;
        fuse_val      = '0;
        last_rd       = '0;
        efuse_exp     = '0;
        repeat (3) @(negedge tck);
        checkOutput("reset_ctrl", W'({dr_busy, dr_done, capt, shft, din}), '0);
        checkOutput("reset_rd", dr_rd_data, '0);
        tck_rst = 1'b0;

        $display("[TB] capture read");
        preload(32'h0);
        applyStimulus(1'b1, 32'h12345678, 32'hA5A50F0F, 0, 1'b0);

        $display("[TB] no-capture shift");
        preload(32'hDEADBEEF);
        applyStimulus(1'b0, 32'h0, 32'h0BADF00D, 0, 1'b0);

        $display("[TB] start ignored while busy");
        applyStimulus(1'b1, $urandom, $urandom, 10, 1'b1);
        idleWatch(5);

        $display("[TB] reset mid-shift");
        resetMidShift();
        applyStimulus(1'b1, $urandom, 32'hFFFF0000, 0, 1'b0);

        $display("[TB] back-to-back");
        applyStimulus(1'b1, 32'h00000001, $urandom, 0, 1'b0);
        applyStimulus(1'b1, 32'h80000000, 32'h00000001, 0, 1'b0);

        $display("[TB] random transactions");
        for (int i = 0; i < 20; i++) begin
            cap = 1'($urandom);
            a   = $urandom;
            b   = $urandom;
            if ($urandom_range(0, 3) == 0) preload($urandom);
            applyStimulus(cap, a, b, int'($urandom_range(0, 20)), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
